data_island_scheduler: RTL and testbench

DATA_ISLAND_SCHEDULER -- requirements
Module: data_island_scheduler

---
 rtl/data_island_scheduler.sv | 178 +++++++++++++++++
 tb/tb_data_island_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_island_scheduler.sv
// Data island sequencer: preamble, leading guard, back-to-back 32-cycle packets with
// round-robin source arbitration, trailing guard. All outputs registered off clk_pixel.
module data_island_scheduler #(
    parameter int BIT_WIDTH    = 9,
    parameter int ISLAND_START = 20,
    parameter int ISLAND_END   = 128,
    parameter int MAX_PACKETS  = 2
) (
    input  logic                 clk_pixel,
    input  logic                 reset_n,
    input  logic [BIT_WIDTH:0]   cx,
    input  logic [2:0]           req,
    output logic [2:0]           mode,
    output logic                 preamble,
    output logic [2:0]           grant,
    output logic                 grant_start,
    output logic [4:0]           packet_index,
    output logic                 busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_LEAD     = 3'd2;
    localparam logic [2:0] S_PACKET   = 3'd3;
    localparam logic [2:0] S_TRAIL    = 3'd4;

    localparam logic [2:0] MODE_CTRL  = 3'd0;
    localparam logic [2:0] MODE_DATA  = 3'd3;
    localparam logic [2:0] MODE_GUARD = 3'd4;

    localparam logic [BIT_WIDTH:0] START_CX = ISLAND_START[BIT_WIDTH:0];
    localparam logic [4:0]         MAX_PKT  = 5'(MAX_PACKETS);
    // A further packet needs 32 data cycles plus 2 guard cycles before ISLAND_END.
    localparam int                 ROOM_LIMIT = ISLAND_END - 34;

    logic [2:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [4:0] pkt_cnt_q, pkt_cnt_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [2:0] mode_q, mode_d;
    logic       preamble_q, preamble_d;
    logic [2:0] grant_q, grant_d;
    logic       grant_start_q, grant_start_d;
    logic [4:0] packet_index_q, packet_index_d;
    logic       busy_q, busy_d;

    logic       room_ok;
    logic       start_packet;
    logic [2:0] arb_grant;
    logic [1:0] arb_next_ptr;
    logic [1:0] cand_idx [3];

    assign room_ok = (int'(cx) <= ROOM_LIMIT);

    // cand_idx[k] is the k-th source visited, starting at the round-robin pointer.
    for (genvar gi = 0; gi < 3; gi++) begin : g_cand
        logic [2:0] sum;
        assign sum          = {1'b0, rr_ptr_q} + 3'(gi);
        assign cand_idx[gi] = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    end

    always_comb begin
        arb_grant    = 3'b000;
        arb_next_ptr = rr_ptr_q;
        for (int k = 2; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                arb_grant    = 3'b001 << cand_idx[k];
                arb_next_ptr = (cand_idx[k] == 2'd2) ? 2'd0 : cand_idx[k] + 2'd1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + 3'd1;
        pkt_cnt_d      = pkt_cnt_q;
        rr_ptr_d       = rr_ptr_q;
        grant_d        = grant_q;
        grant_start_d  = 1'b0;
        packet_index_d = packet_index_q + 5'd1;
        start_packet   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (cx == START_CX && |req) begin
                    state_d   = S_PREAMBLE;
                    pkt_cnt_d = '0;
                end
            end
            S_PREAMBLE: begin
                if (cnt_q == 3'd7) begin
                    state_d = S_LEAD;
                    cnt_d   = '0;
                end
            end
            S_LEAD: begin
                if (cnt_q == 3'd1) begin
                    start_packet = 1'b1;
                end
            end
            S_PACKET: begin
                if (packet_index_q == 5'd31) begin
                    if (|req && (pkt_cnt_q < MAX_PKT) && room_ok) begin
                        start_packet = 1'b1;
                    end else begin
                        state_d = S_TRAIL;
                        cnt_d   = '0;
                    end
                end
            end
            S_TRAIL: begin
                if (cnt_q == 3'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An empty arbitration still opens a (null) packet; the pointer then stays put.
        if (start_packet) begin
            state_d        = S_PACKET;
            grant_d        = arb_grant;
            rr_ptr_d       = arb_next_ptr;
            grant_start_d  = 1'b1;
            packet_index_d = '0;
            pkt_cnt_d      = pkt_cnt_q + 5'd1;
        end

        if (state_d != S_PACKET) begin
            grant_d        = '0;
            packet_index_d = '0;
        end

        mode_d = MODE_CTRL;
        if (state_d == S_PACKET) begin
            mode_d = MODE_DATA;
        end else if (state_d == S_LEAD || state_d == S_TRAIL) begin
            mode_d = MODE_GUARD;
        end
        preamble_d = (state_d == S_PREAMBLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            pkt_cnt_q      <= '0;
            rr_ptr_q       <= '0;
            mode_q         <= MODE_CTRL;
            preamble_q     <= 1'b0;
            grant_q        <= '0;
            grant_start_q  <= 1'b0;
            packet_index_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pkt_cnt_q      <= pkt_cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            mode_q         <= mode_d;
            preamble_q     <= preamble_d;
            grant_q        <= grant_d;
            grant_start_q  <= grant_start_d;
            packet_index_q <= packet_index_d;
            busy_q         <= busy_d;
        end
    end

    assign mode         = mode_q;
    assign preamble     = preamble_q;
    assign grant        = grant_q;
    assign grant_start  = grant_start_q;
    assign packet_index = packet_index_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_data_island_scheduler.sv
// Bench for data_island_scheduler: directed line scenarios, then random requests/resets,
// every cycle compared against an offset-based island schedule model.
module tb_data_island_scheduler;

    localparam int START    = 20;
    localparam int LINE_LEN = 858;
    localparam int MAXP     = 2;
    localparam int END0     = 128;
    localparam int END1     = 70;

    logic       clk_pixel;
    logic       reset_n;
    logic [9:0] cx;
    logic [2:0] req;

    logic [2:0] mode0, mode1;
    logic       preamble0, preamble1;
    logic [2:0] grant0, grant1;
    logic       grant_start0, grant_start1;
    logic [4:0] packet_index0, packet_index1;
    logic       busy0, busy1;

    int total = 0;
    int bad   = 0;

    data_island_scheduler #(.ISLAND_END(END0)) dut0 (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .cx(cx), .req(req),
        .mode(mode0), .preamble(preamble0), .grant(grant0),
        .grant_start(grant_start0), .packet_index(packet_index0), .busy(busy0)
    );

    data_island_scheduler #(.ISLAND_END(END1)) dut1 (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .cx(cx), .req(req),
        .mode(mode1), .preamble(preamble1), .grant(grant1),
        .grant_start(grant_start1), .packet_index(packet_index1), .busy(busy1)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    // Model: island described by output offset o since opening (0..7 preamble,
    // 8..9 lead guard, then 32-cycle packets, then 2 guard cycles from trail_at).
    int         m_active [2];
    int         m_o      [2];
    int         m_npk    [2];
    int         m_trail  [2];
    int         m_ptr    [2];
    logic [2:0] m_grant  [2];
    logic [13:0] m_exp   [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int m, input int end_cx);
        int pi;
        int idx;
        logic [2:0] g;
        if (!reset_n) begin
            m_active[m] = 0;
            m_ptr[m]    = 0;
        end else if (m_active[m] == 0) begin
            if (int'(cx) == START && req != 3'b000) begin
                m_active[m] = 1;
                m_o[m]      = 0;
                m_npk[m]    = 0;
                m_trail[m]  = -1;
            end
        end else begin
            m_o[m]++;
            if (m_trail[m] >= 0) begin
                if (m_o[m] >= m_trail[m] + 2) m_active[m] = 0;
            end else if (m_o[m] == 10 || (m_o[m] > 10 && (m_o[m] - 10) % 32 == 0)) begin
                if (m_o[m] == 10 || (req != 3'b000 && m_npk[m] < MAXP && int'(cx) <= end_cx - 34)) begin
                    g = 3'b000;
                    for (int k = 0; k < 3; k++) begin
                        idx = (m_ptr[m] + k) % 3;
                        if (g == 3'b000 && req[idx]) begin
                            g        = 3'(1 << idx);
                            m_ptr[m] = (idx + 1) % 3;
                        end
                    end
                    m_grant[m] = g;
                    m_npk[m]++;
                end else begin
                    m_trail[m] = m_o[m];
                end
            end
        end
        // packing: {mode, preamble, grant, grant_start, packet_index, busy}
        if (m_active[m] == 0)       m_exp[m] = 14'd0;
        else if (m_o[m] < 8)        m_exp[m] = {3'd0, 1'b1, 3'd0, 1'b0, 5'd0, 1'b1};
        else if (m_o[m] < 10)       m_exp[m] = {3'd4, 1'b0, 3'd0, 1'b0, 5'd0, 1'b1};
        else if (m_trail[m] >= 0)   m_exp[m] = {3'd4, 1'b0, 3'd0, 1'b0, 5'd0, 1'b1};
        else begin
            pi       = (m_o[m] - 10) % 32;
            m_exp[m] = {3'd3, 1'b0, m_grant[m], (pi == 0), 5'(pi), 1'b1};
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        model_step(0, END0);
        model_step(1, END1);
        #1;
        check("cyc_dut0", {mode0, preamble0, grant0, grant_start0, packet_index0, busy0}, m_exp[0]);
        check("cyc_dut1", {mode1, preamble1, grant1, grant_start1, packet_index1, busy1}, m_exp[1]);
        if (grant_start0)
            $display("packet cx=%0d grant0=%b grant1=%b grant_start1=%b", cx + 10'd1, grant0, grant1, grant_start1);
        cx = (int'(cx) == LINE_LEN - 1) ? 10'd0 : cx + 10'd1;
    endtask

    task automatic go_until(input int c);
        int n;
        n = 0;
        while (int'(cx) != c && n < 2 * LINE_LEN) begin
            tick();
            n++;
        end
        if (int'(cx) != c) check("go_until_timeout", 32'(cx), 32'(c));
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_active[m] = 0; m_o[m] = 0; m_npk[m] = 0; m_trail[m] = -1; m_ptr[m] = 0;
            m_grant[m] = 3'b000; m_exp[m] = 14'd0;
        end
        reset_n = 1'b0;
        cx      = 10'd0;
        req     = 3'b000;

        // Reset state
        repeat (3) tick();
        check("rst_mode", 32'(mode0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_grant", 32'(grant1), 32'd0);

        // Single source, request dropped once granted
        reset_n = 1'b1;
        req     = 3'b001;
        go_until(21);  check("one_pre21", 32'(preamble0), 32'd1);
        go_until(28);  check("one_pre28", 32'(preamble0), 32'd1);
        go_until(29);  check("one_guard29", 32'(mode0), 32'd4);
        go_until(31);  check("one_grant31", 32'(grant0), 32'b001);
                       check("one_gs31", 32'(grant_start0), 32'd1);
        go_until(32);  check("one_gs32", 32'(grant_start0), 32'd0);
        req = 3'b000;
        go_until(62);  check("one_idx62", 32'(packet_index0), 32'd31);
        go_until(63);  check("one_trail63", 32'(mode0), 32'd4);
                       check("one_grant63", 32'(grant0), 32'd0);
        go_until(65);  check("one_idle65", 32'(busy0), 32'd0);

        // All sources, fresh pointer
        go_until(855);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req     = 3'b111;
        go_until(31);  check("all_g31_d0", 32'(grant0), 32'b001);
                       check("all_g31_d1", 32'(grant1), 32'b001);
        go_until(63);  check("all_g63_d0", 32'(grant0), 32'b010);
                       check("all_gs63_d0", 32'(grant_start0), 32'd1);
                       check("room_trail63", 32'(mode1), 32'd4);
        go_until(65);  check("room_idle65", 32'(busy1), 32'd0);
        go_until(95);  check("all_trail95", 32'(mode0), 32'd4);
        go_until(97);  check("all_idle97", 32'(busy0), 32'd0);
        go_until(31);  check("all2_g31_d0", 32'(grant0), 32'b100);
                       check("all2_g31_d1", 32'(grant1), 32'b010);
        go_until(63);  check("all2_g63_d0", 32'(grant0), 32'b001);

        // Late request: no island this line, opens next line
        req = 3'b000;
        go_until(25);
        req = 3'b001;
        go_until(40);  check("late_idle40", 32'(busy0), 32'd0);
        go_until(21);  check("late_pre21", 32'(preamble0), 32'd1);

        // Reset mid-packet
        go_until(41);  check("rst_idx10", 32'(packet_index0), 32'd10);
        reset_n = 1'b0;
        tick();
        check("midrst_mode", 32'(mode0), 32'd0);
        check("midrst_grant", 32'(grant0), 32'd0);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_idx", 32'(packet_index0), 32'd0);
        reset_n = 1'b1;
        go_until(100); check("midrst_noisland", 32'(busy0), 32'd0);

        // Withdrawal during lead guard gives a null packet
        go_until(29);
        req = 3'b000;
        go_until(31);  check("null_grant31", 32'(grant0), 32'd0);
                       check("null_gs31", 32'(grant_start0), 32'd1);
                       check("null_mode31", 32'(mode0), 32'd3);
        go_until(62);  check("null_mode62", 32'(mode0), 32'd3);
        go_until(63);  check("null_trail63", 32'(mode0), 32'd4);

        // Random requests and occasional resets
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 199) == 0) req = 3'($urandom_range(0, 7));
            reset_n = ($urandom_range(0, 2999) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
